gate_response_checker: RTL



---
 rtl/gate_response_checker.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/gate_response_checker.sv
// Response checker for a 2-input combinational gate: synchronises the gate's
// inputs and output, waits for stable inputs, then compares against TRUTH.
module gate_response_checker #(
    parameter logic [3:0]  TRUTH  = 4'b1000,
    parameter int unsigned SETTLE = 4,
    parameter int unsigned ERR_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             a_i,
    input  logic             b_i,
    input  logic             y_i,
    output logic             mismatch_o,
    output logic [ERR_W-1:0] err_cnt_o,
    output logic [3:0]       covered_o,
    output logic             done_o,
    output logic             pass_o
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SETTLE = 2'b01,
        ST_CHECK  = 2'b10,
        ST_HOLD   = 2'b11
    } state_t;

    localparam logic [3:0]       SETTLE_LOAD = 4'(SETTLE - 1);
    localparam logic [ERR_W-1:0] ERR_MAX     = {ERR_W{1'b1}};

    function automatic logic [ERR_W-1:0] satInc(input logic [ERR_W-1:0] value);
        if (value == ERR_MAX) begin
            satInc = value;
        end else begin
            satInc = value + ERR_W'(1'b1);
        end
    endfunction

    // Synchroniser bit order: {a, b, y}
    logic [2:0]       inMeta_r;
    logic [2:0]       inSync_r;
    logic [1:0]       combo_s;
    state_t           state_r;
    state_t           stateNext_s;
    logic [3:0]       settleCnt_r;
    logic [3:0]       settleCntNext_s;
    logic [1:0]       curCombo_r;
    logic [1:0]       curComboNext_s;
    logic             checkFire_s;
    logic             checkFail_s;
    logic             mismatch_r;
    logic [ERR_W-1:0] errCnt_r;
    logic [3:0]       covered_r;
    logic             done_r;
    logic             pass_r;

    assign combo_s = inSync_r[2:1];

    // Two-flop synchronisers for the asynchronous gate signals
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inMeta_r <= 3'b000;
            inSync_r <= 3'b000;
        end else begin
            inMeta_r <= {a_i, b_i, y_i};
            inSync_r <= inMeta_r;
        end
    end

    // FSM state, settle counter and captured combination registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            settleCnt_r <= 4'd0;
            curCombo_r  <= 2'b00;
        end else begin
            state_r     <= stateNext_s;
            settleCnt_r <= settleCntNext_s;
            curCombo_r  <= curComboNext_s;
        end
    end

    // Next-state logic; a CHECK still fires when en drops, but never under clr
    always_comb begin
        stateNext_s     = state_r;
        settleCntNext_s = settleCnt_r;
        curComboNext_s  = curCombo_r;
        checkFire_s     = 1'b0;
        if (clr) begin
            stateNext_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (en) begin
                        stateNext_s     = ST_SETTLE;
                        settleCntNext_s = SETTLE_LOAD;
                        curComboNext_s  = combo_s;
                    end else begin
                        stateNext_s = ST_IDLE;
                    end
                end
                ST_SETTLE: begin
                    if (combo_s != curCombo_r) begin
                        curComboNext_s  = combo_s;
                        settleCntNext_s = SETTLE_LOAD;
                    end else if (settleCnt_r == 4'd0) begin
                        stateNext_s = ST_CHECK;
                    end else begin
                        settleCntNext_s = settleCnt_r - 4'd1;
                    end
                end
                ST_CHECK: begin
                    checkFire_s = 1'b1;
                    stateNext_s = ST_HOLD;
                end
                ST_HOLD: begin
                    if (combo_s != curCombo_r) begin
                        curComboNext_s  = combo_s;
                        settleCntNext_s = SETTLE_LOAD;
                        stateNext_s     = ST_SETTLE;
                    end else begin
                        stateNext_s = ST_HOLD;
                    end
                end
                default: begin
                    stateNext_s = ST_IDLE;
                end
            endcase
            if (!en) begin
                stateNext_s = ST_IDLE;
            end else begin
                stateNext_s = stateNext_s;
            end
        end
        checkFail_s = checkFire_s && (inSync_r[0] != TRUTH[curCombo_r]);
    end

    // Result registers: mismatch pulse, saturating count, coverage and flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mismatch_r <= 1'b0;
            errCnt_r   <= {ERR_W{1'b0}};
            covered_r  <= 4'b0000;
            done_r     <= 1'b0;
            pass_r     <= 1'b0;
        end else if (clr) begin
            mismatch_r <= 1'b0;
            errCnt_r   <= {ERR_W{1'b0}};
            covered_r  <= 4'b0000;
            done_r     <= 1'b0;
            pass_r     <= 1'b0;
        end else begin
            mismatch_r <= checkFail_s;
            if (checkFail_s) begin
                errCnt_r <= satInc(errCnt_r);
            end else begin
                errCnt_r <= errCnt_r;
            end
            if (checkFire_s) begin
                covered_r <= covered_r | (4'b0001 << curCombo_r);
            end else begin
                covered_r <= covered_r;
            end
            done_r <= &covered_r;
            pass_r <= (&covered_r) && (errCnt_r == {ERR_W{1'b0}});
        end
    end

    assign mismatch_o = mismatch_r;
    assign err_cnt_o  = errCnt_r;
    assign covered_o  = covered_r;
    assign done_o     = done_r;
    assign pass_o     = pass_r;

endmodule
